instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetches the scene program from instruction memory and streams it one word per cycle into the instruction parser. It sits between the program BRAM and the parser and throttles on downstream backpressure. It also sequences rendering: it stops at render instructions until the renderer finishes, and at frame instructions until the next frame sync, after which it replays the program from address 0.

## Interface
- ADDR_W, 10, instruction memory address width
- MEM_LAT, 2, BRAM read latency in cycles (1..3)
- FTYPE_OPC, 3'b000, opcode in bits [2:0] of frame/render instructions
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begin program at address 0; ignored unless IDLE
- prog_len  in  ADDR_W  program length in words; sampled on accepted start
- imem_addr  out  ADDR_W  BRAM read address
- imem_rdata  in  32  BRAM data, valid MEM_LAT cycles after address
- inst  out  32  word to parser
- inst_valid  out  1  parser valid_in
- dec_valid  in  1  parser valid_out
- dec_render  in  1  parser output is a render instruction
- dec_frame  in  1  parser output is a frame instruction
- ds_ready  in  1  downstream can accept a word this cycle
- render_start  out  1  one-cycle pulse to renderer
- render_done  in  1  one-cycle pulse from renderer
- frame_sync  in  1  vsync pulse
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at program end without a frame instruction
- frame_count  out  16  completed frames, wraps at 2^16

## Operation
- The reset value of every output is 0. After reset the block is in IDLE with the FIFO empty and nothing in flight.
- States and transitions:
  - IDLE: an accepted start goes to FETCH.
  - FETCH: dec_render goes to WAIT_RENDER. dec_frame goes to WAIT_FRAME. End of program goes to IDLE.
  - WAIT_RENDER: render_done goes back to FETCH.
  - WAIT_FRAME: frame_sync goes to FETCH.
- Fetch:
  - In FETCH, a read is issued when rd_addr < prog_len_q and (fifo_count + inflight) < MEM_LAT+2.
  - On each issue, rd_addr increments.
  - A MEM_LAT-deep valid shift register tracks reads in flight. Returning data is pushed into a skid FIFO of depth MEM_LAT+2.
  - The FIFO can never overflow. An overflow is an assertion failure.
- Present:
  - inst/inst_valid are registered.
  - In FETCH, when the FIFO is non-empty, ds_ready=1 and there is no holdoff, the head word is popped and inst_valid=1 is driven on the next cycle. Otherwise inst_valid=0 and inst holds its value.
- Holdoff:
  - Presenting a word with bits [2:0]==FTYPE_OPC blocks presentation for the following cycle, while the parser result is pending.
  - This applies to shape-data words that match FTYPE_OPC too; the only cost is one bubble.
- Render:
  - When dec_valid && dec_render, render_start pulses the next cycle and the state goes to WAIT_RENDER.
  - The FIFO contents are kept, and fetch continues filling the FIFO.
  - On render_done the state returns to FETCH, and presentation resumes the cycle after that.
- Frame:
  - When dec_valid && dec_frame, the state goes to WAIT_FRAME.
  - On the transition the FIFO is flushed, in-flight returns are discarded and rd_addr is set to 0.
  - On frame_sync, frame_count increments and the state returns to FETCH.
- End of program:
  - When rd_addr==prog_len_q, inflight==0, the FIFO is empty, the state is FETCH and no dec result is pending, done pulses and the state goes to IDLE.
  - A start with prog_len=0 produces a done pulse 2 cycles after start and no reads.
- Simultaneous events:
  - dec_render and dec_frame both high: frame wins.
  - render_done arriving outside WAIT_RENDER is ignored.
  - frame_sync arriving outside WAIT_FRAME is ignored.
- A rst asserted mid-operation aborts immediately and discards all in-flight data. frame_count is cleared.

## Timing
- Start to first imem_addr issue: 1 cycle.
- First inst_valid appears MEM_LAT+2 cycles after start, given ds_ready=1.
- Steady-state throughput is 1 word/cycle, except for holdoff bubbles.
- dec_* arrives 1 cycle after inst_valid. render_start follows dec_render by 1 cycle.
- render_done to the next inst_valid: 2 cycles.
- frame_sync to the first re-fetched inst_valid: MEM_LAT+2 cycles.

## Test plan
- prog_len=4, no F-type words, ds_ready=1, start → inst_valid high for 4 consecutive cycles with words 0..3 in order, then a done pulse; frame_count stays 0.
- Same program with ds_ready toggled 1,0,1,0 → all 4 words delivered once each, in order; inst_valid is never high while ds_ready was 0 in the prior cycle; no FIFO overflow.
- Word 2 is a render instruction (parser model asserts dec_render), render_done held off 20 cycles → render_start pulses once; no inst_valid until 2 cycles after render_done; then word 3 is delivered.
- Word 1 is a frame instruction, frame_sync pulse 10 cycles later → no further words delivered; frame_count=1; replay starts at word 0, MEM_LAT+2 cycles after sync.
- Shape-data word with bits[2:0]=000 and dec_render=0 → exactly one bubble; stream continues; no render_start.
- rst asserted while in WAIT_RENDER, then start with prog_len=0 → all outputs 0 after reset; done pulses 2 cycles after start; imem_addr is never advanced.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Streams the scene program from the instruction BRAM into the instruction
// parser, one word per cycle, throttled by downstream backpressure. Render
// instructions park the sequencer until the renderer reports completion;
// frame instructions park it until the next frame sync, after which the
// program is replayed from address 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, prog_len   begin a program of prog_len words (accepted in IDLE only)
//   imem_addr         BRAM read address
//   imem_rdata        BRAM data, valid MEM_LAT cycles after its address
//   inst, inst_valid  registered word and valid towards the parser
//   dec_valid         parser result valid
//   dec_render        parser result is a render instruction
//   dec_frame         parser result is a frame instruction
//   ds_ready          downstream can accept a word this cycle
//   render_start      one-cycle pulse to the renderer
//   render_done       one-cycle pulse from the renderer
//   frame_sync        vsync pulse
//   busy              sequencer is not IDLE
//   done              one-cycle pulse when the program ends without a frame
//   frame_count       completed frames, wraps at 2^16
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int         ADDR_W    = 10,
    parameter int         MEM_LAT   = 2,
    parameter logic [2:0] FTYPE_OPC = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              dec_valid,
    input  logic              dec_render,
    input  logic              dec_frame,
    input  logic              ds_ready,
    output logic              render_start,
    input  logic              render_done,
    input  logic              frame_sync,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count
);

    localparam int DEPTH = MEM_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_FETCH       = 2'd1;
    localparam logic [1:0] S_WAIT_RENDER = 2'd2;
    localparam logic [1:0] S_WAIT_FRAME  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] prog_len_q;
    logic [MEM_LAT-1:0] vld_sr;       // one bit per read in flight
    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;

    logic ret_valid, fifo_empty, fifo_full, holdoff, in_fetch;
    logic dec_frame_hit, dec_render_hit, pop, pop_fifo, push, issue, room, prog_end;
    logic [31:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal written here gets a value before any condition,
    // otherwise a path that skips the assignment would infer a latch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sr[i]);
        end
    end

    assign ret_valid  = vld_sr[MEM_LAT-1];
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
    assign in_fetch   = (state == S_FETCH);

    // A word whose opcode looks like a frame/render instruction stalls the
    // next presentation slot until the parser has classified it.
    assign holdoff        = inst_valid && (inst[2:0] == FTYPE_OPC);
    assign dec_frame_hit  = dec_valid && dec_frame;
    assign dec_render_hit = dec_valid && dec_render && !dec_frame;

    // Fall-through FIFO: when empty, returning BRAM data is presented
    // directly so the first word is not delayed by a write cycle.
    assign head     = fifo_empty ? imem_rdata : fifo_mem[rd_ptr];
    assign pop      = in_fetch && (!fifo_empty || ret_valid) && ds_ready && !holdoff
                      && !(dec_valid && (dec_render || dec_frame));
    assign pop_fifo = pop && !fifo_empty;
    assign push     = ret_valid && !(pop && fifo_empty);

    // Reads are only issued when a slot is guaranteed for their return data.
    assign room  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
    assign issue = (in_fetch || state == S_WAIT_RENDER) && (rd_addr < prog_len_q) && room;

    assign prog_end = in_fetch && (rd_addr == prog_len_q) && (inflight == '0)
                      && fifo_empty && !inst_valid;

    assign imem_addr = rd_addr;
    assign busy      = (state != S_IDLE);

    // NOTE: the FIFO storage has no reset; fifo_count and the pointers alone
    // decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= imem_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_addr      <= '0;
            prog_len_q   <= '0;
            vld_sr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            inst         <= '0;
            inst_valid   <= 1'b0;
            render_start <= 1'b0;
            done         <= 1'b0;
            frame_count  <= '0;
        end else begin
            render_start <= 1'b0;
            done         <= 1'b0;

            for (int i = MEM_LAT - 1; i > 0; i--) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            vld_sr[0] <= issue;
            if (issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fifo) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop_fifo) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop_fifo) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end

            inst_valid <= pop;
            if (pop) begin
                inst <= head;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        prog_len_q <= prog_len;
                        rd_addr    <= '0;
                    end
                end
                S_FETCH: begin
                    if (dec_frame_hit) begin
                        // Replay from the top: drop everything fetched ahead.
                        state      <= S_WAIT_FRAME;
                        fifo_count <= '0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        vld_sr     <= '0;
                        rd_addr    <= '0;
                    end else if (dec_render_hit) begin
                        state        <= S_WAIT_RENDER;
                        render_start <= 1'b1;
                    end else if (prog_end) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_WAIT_RENDER: begin
                    if (render_done) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    if (frame_sync) begin
                        state       <= S_FETCH;
                        frame_count <= frame_count + 16'd1;
                    end
                end
            endcase
        end
    end

    fifo_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop_fifo));

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Drives instr_sequencer with a BRAM model, a parser model and a renderer /
// vsync responder. Delivered words and event times are logged by a monitor
// and compared against expectations derived from the program contents and
// the documented latencies.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int         ADDR_W  = 10;
    localparam int         MEM_LAT = 2;
    localparam logic [2:0] FT      = 3'b000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] prog_len = '0;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = '0;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              dec_valid = 1'b0;
    logic              dec_render = 1'b0;
    logic              dec_frame = 1'b0;
    logic              ds_ready = 1'b1;
    logic              render_start;
    logic              render_done = 1'b0;
    logic              frame_sync = 1'b0;
    logic              busy;
    logic              done;
    logic [15:0]       frame_count;

    instr_sequencer #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .FTYPE_OPC(FT)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .dec_valid(dec_valid), .dec_render(dec_render), .dec_frame(dec_frame),
        .ds_ready(ds_ready), .render_start(render_start), .render_done(render_done),
        .frame_sync(frame_sync), .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Configuration written by the stimulus process only.
    logic [31:0] prog_mem [1024];
    int ready_mode   = 0;   // 0: always ready, 1: random, 2: toggle
    int render_delay = 5;
    int frame_delay  = 10;

    // State written by the environment process only.
    logic [ADDR_W-1:0] ahist [MEM_LAT] = '{default: '0};
    logic        prev_iv = 1'b0;
    logic [31:0] prev_inst = '0;
    logic        prev_ready = 1'b1;
    int rd_cnt = 0, fs_cnt = 0;
    logic [31:0] got_q [$];
    int          got_cyc [$];
    int rs_cnt = 0, rs_cyc = 0, rd_cyc = 0, done_cnt = 0, done_cyc = 0;
    int fs_total = 0, fs_cyc = 0, ready_viol = 0, hold_viol = 0, addr_nz = 0;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Environment: monitor outputs mid-cycle and drive responder inputs.
    always @(negedge clk) begin
        if (rst) begin
            prev_iv = 1'b0; prev_inst = '0; prev_ready = 1'b1;
            rd_cnt = 0; fs_cnt = 0;
            dec_valid = 1'b0; dec_render = 1'b0; dec_frame = 1'b0;
            render_done = 1'b0; frame_sync = 1'b0; ds_ready = 1'b1; imem_rdata = '0;
        end else begin
            if (inst_valid) begin
                got_q.push_back(inst);
                got_cyc.push_back(cyc);
                if (!prev_ready) ready_viol++;
                if (prev_iv && prev_inst[2:0] == FT) hold_viol++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (imem_addr != '0) addr_nz++;

            render_done = 1'b0;
            frame_sync  = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin render_done = 1'b1; rd_cyc = cyc; end
            end
            if (fs_cnt > 0) begin
                fs_cnt--;
                if (fs_cnt == 0) begin frame_sync = 1'b1; fs_cyc = cyc; fs_total++; end
            end
            if (render_start) begin rs_cnt++; rs_cyc = cyc; rd_cnt = render_delay; end

            // Parser: classifies the word one cycle after it was presented.
            dec_valid  = prev_iv;
            dec_render = prev_iv && prev_inst[31:30] == 2'b01;
            dec_frame  = prev_iv && prev_inst[31:30] == 2'b10;
            if (dec_frame) fs_cnt = frame_delay;

            // BRAM: data for the address seen MEM_LAT cycles ago.
            imem_rdata = prog_mem[ahist[MEM_LAT-1]];
            for (int i = MEM_LAT - 1; i > 0; i--) ahist[i] = ahist[i-1];
            ahist[0] = imem_addr;

            case (ready_mode)
                0:       ds_ready = 1'b1;
                1:       ds_ready = 1'($urandom_range(0, 1));
                default: ds_ready = !ds_ready;
            endcase
            prev_ready = ds_ready;
            prev_iv    = inst_valid;
            prev_inst  = inst;
        end
    end

    // Word layout: [31:30] 01 = render, 10 = frame, 00 = shape data.
    task automatic gen_prog(input int len, input int rend_idx, input bit zero_ok, input int rend_pct);
        logic [31:0] w;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            w[31:30] = 2'b00;
            if (!zero_ok && w[2:0] == FT) w[0] = ~w[0];
            if (i == rend_idx || int'($urandom_range(0, 99)) < rend_pct) begin
                w[31:30] = 2'b01;
                w[2:0]   = FT;
            end
            prog_mem[i] = w;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_inst"}, inst, 32'h0);
        check({pfx, "_inst_valid"}, 32'(inst_valid), 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_done"}, 32'(done), 32'h0);
        check({pfx, "_render_start"}, 32'(render_start), 32'h0);
        check({pfx, "_frame_count"}, 32'(frame_count), 32'h0);
        check({pfx, "_imem_addr"}, 32'(imem_addr), 32'h0);
    endtask

    task automatic kick(input int len, output int s);
        @(posedge clk); #1;
        start = 1'b1; prog_len = ADDR_W'(len); s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs a program without frame instructions to completion and checks it.
    task automatic run_prog(input int len, input int rmode, input int rdel);
        int s, bw, bd, brs, brv, bhv, ban, nr, n, exp_c;
        ready_mode = rmode; render_delay = rdel;
        bw = got_q.size(); bd = done_cnt; brs = rs_cnt;
        brv = ready_viol; bhv = hold_viol; ban = addr_nz;
        kick(len, s);
        for (int t = 0; t < 4000 && done_cnt == bd; t++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - bd, 1);
        n = got_q.size() - bw;
        check("word_count", n, len);
        nr = 0;
        for (int i = 0; i < len; i++) begin
            if (prog_mem[i][31:30] == 2'b01) nr++;
            if (i < n) check($sformatf("word[%0d]", i), got_q[bw+i], prog_mem[i]);
        end
        check("render_starts", rs_cnt - brs, nr);
        check("ready_rule", ready_viol - brv, 0);
        check("holdoff_rule", hold_viol - bhv, 0);
        check("busy_after_done", 32'(busy), 0);
        check("frame_count_idle", 32'(frame_count), 0);
        if (len == 0) begin
            check("done_latency", done_cyc - s, 2);
            check("addr_moved", addr_nz - ban, 0);
        end
        if (rmode == 0 && n > 0) begin
            check("first_latency", got_cyc[bw] - s, MEM_LAT + 2);
            for (int i = 1; i < n; i++) begin
                if (prog_mem[i-1][31:30] == 2'b01) exp_c = rd_cyc + 2;
                else exp_c = got_cyc[bw+i-1] + ((prog_mem[i-1][2:0] == FT) ? 2 : 1);
                check($sformatf("timing[%0d]", i), got_cyc[bw+i], exp_c);
            end
        end
    endtask

    initial begin
        int s, bw, brs, bfs, bd, n;
        for (int i = 0; i < 1024; i++) prog_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Plain four-word program, back to back.
        gen_prog(4, -1, 1'b0, 0);
        run_prog(4, 0, 5);

        // Same program with ds_ready toggling every cycle.
        run_prog(4, 2, 5);

        // Render instruction at word 2, renderer busy for 20 cycles.
        gen_prog(4, 2, 1'b0, 0);
        bw = got_q.size();
        run_prog(4, 0, 20);
        if (got_q.size() - bw >= 3) check("render_start_lat", rs_cyc - got_cyc[bw+2], 2);

        // Shape-data word that looks like a frame/render opcode: one bubble.
        gen_prog(6, -1, 1'b0, 0);
        prog_mem[1][2:0] = FT;
        run_prog(6, 0, 5);

        // Randomised programs, renders and backpressure.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 40));
            gen_prog(n, -1, 1'b1, 10);
            run_prog(n, 1, int'($urandom_range(1, 15)));
        end

        // Frame instruction at word 1, vsync 10 cycles after it is decoded.
        gen_prog(6, -1, 1'b0, 0);
        prog_mem[1][31:30] = 2'b10;
        prog_mem[1][2:0]   = FT;
        ready_mode = 0; frame_delay = 10;
        bw = got_q.size(); bfs = fs_total; bd = done_cnt;
        kick(6, s);
        for (int t = 0; t < 1000 && got_q.size() - bw < 3; t++) begin @(posedge clk); #1; end
        n = got_q.size() - bw;
        check("frame_words_seen", 32'(n >= 3), 1);
        if (n >= 3) begin
            check("frame_w0", got_q[bw], prog_mem[0]);
            check("frame_w1", got_q[bw+1], prog_mem[1]);
            check("replay_w0", got_q[bw+2], prog_mem[0]);
            check("replay_latency", got_cyc[bw+2] - fs_cyc, MEM_LAT + 2);
        end
        check("frame_syncs", fs_total - bfs, 1);
        check("frame_count", 32'(frame_count), 1);
        check("frame_no_done", done_cnt - bd, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("frame_count_cleared", 32'(frame_count), 0);
        rst = 1'b0;

        // Reset while parked in WAIT_RENDER, then an empty program.
        gen_prog(4, 0, 1'b0, 0);
        ready_mode = 0; render_delay = 5000;
        brs = rs_cnt;
        kick(4, s);
        for (int t = 0; t < 200 && rs_cnt == brs; t++) begin @(posedge clk); #1; end
        check("render_entered", rs_cnt - brs, 1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_wait", 32'(busy), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        run_prog(0, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
